// File: rtl/multicycle_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL and DIVU.
// Optional build macro MULTICYCLE_ALU_OVERFLOW_EN enables the signed ADD/SUB overflow flag.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       control_signal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             is_zero,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             overflow
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic                    accept;
    logic                    start_iter;
    logic                    last_step;
    logic                    is_div;
    logic [CNT_W-1:0]        count;
    // part_hi: accumulator / remainder, part_lo: multiplier / quotient, part_op: multiplicand / divisor
    logic [WIDTH-1:0]        part_hi;
    logic [WIDTH-1:0]        part_lo;
    logic [WIDTH-1:0]        part_op;
    logic [WIDTH-1:0]        step_hi;
    logic [WIDTH-1:0]        step_lo;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_trial;
    logic [WIDTH-1:0]        simple_res;
    logic                    simple_ill;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    assign a_s = operand_a;
    assign b_s = operand_b;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign start_iter = (control_signal == OP_MUL) ||
                        ((control_signal == OP_DIVU) && (operand_b != '0));
    assign last_step  = (state == BUSY) && (count == CNT_W'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = start_iter ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = start_iter ? BUSY : DONE;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        simple_res = '0;
        simple_ill = 1'b0;
        case (control_signal)
            OP_AND:  simple_res = operand_a & operand_b;
            OP_OR:   simple_res = operand_a | operand_b;
            OP_ADD:  simple_res = operand_a + operand_b;
            OP_SUB:  simple_res = operand_a - operand_b;
            OP_XOR:  simple_res = operand_a ^ operand_b;
            OP_NOR:  simple_res = ~(operand_a | operand_b);
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
            OP_MUL, OP_DIVU: simple_res = '0;
            default: simple_ill = 1'b1;
        endcase
    end

    // One shift-add (MUL) or one restore-subtract (DIVU) step per BUSY cycle
    always_comb begin
        mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, part_op} : {(WIDTH+1){1'b0}});
        div_trial = {part_hi, part_lo[WIDTH-1]} - {1'b0, part_op};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], part_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {part_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {part_hi[WIDTH-2:0], part_lo[WIDTH-1]};
                step_lo = {part_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            is_div  <= 1'b0;
            part_hi <= '0;
            part_lo <= '0;
            part_op <= '0;
        end else if (accept) begin
            count   <= start_iter ? CNT_W'(WIDTH) : '0;
            is_div  <= (control_signal == OP_DIVU);
            part_hi <= '0;
            part_lo <= (control_signal == OP_MUL) ? operand_b : operand_a;
            part_op <= (control_signal == OP_MUL) ? operand_a : operand_b;
        end else if (state == BUSY) begin
            count   <= count - CNT_W'(1);
            part_hi <= step_hi;
            part_lo <= step_lo;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result      <= '0;
            result_hi   <= '0;
            is_zero     <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (accept && !start_iter) begin
            // A non-iterating DIVU can only be a divide by zero
            if (control_signal == OP_DIVU) begin
                result      <= '1;
                result_hi   <= operand_a;
                is_zero     <= 1'b0;
                div_by_zero <= 1'b1;
                illegal_op  <= 1'b0;
            end else begin
                result      <= simple_res;
                result_hi   <= '0;
                is_zero     <= (simple_res == '0);
                div_by_zero <= 1'b0;
                illegal_op  <= simple_ill;
            end
        end else if (last_step) begin
            result      <= step_lo;
            result_hi   <= step_hi;
            is_zero     <= (step_lo == '0);
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end
    end

`ifdef MULTICYCLE_ALU_OVERFLOW_EN
    function automatic logic add_overflow(input logic signed [WIDTH-1:0] a,
                                          input logic signed [WIDTH-1:0] b,
                                          input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_overflow(input logic signed [WIDTH-1:0] a,
                                          input logic signed [WIDTH-1:0] b,
                                          input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic simple_ovf;

    always_comb begin
        simple_ovf = 1'b0;
        if (control_signal == OP_ADD) begin
            simple_ovf = add_overflow(a_s, b_s, simple_res);
        end else if (control_signal == OP_SUB) begin
            simple_ovf = sub_overflow(a_s, b_s, simple_res);
        end
    end

    // MUL/DIVU accepts load 0 here, which is also their final flag value
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (accept) begin
            overflow <= simple_ovf;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized and directed bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [3:0]    control_signal;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          is_zero;
    logic          div_by_zero;
    logic          illegal_op;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multicycle_alu #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .control_signal (control_signal),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .result_hi      (result_hi),
        .is_zero        (is_zero),
        .div_by_zero    (div_by_zero),
        .illegal_op     (illegal_op),
        .overflow       (overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: results from plain integer arithmetic on the operand values
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic [31:0] rh,
                                     output logic dz, output logic ill, output logic ov,
                                     output int lat);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s = 0;
        r = 0; rh = 0; dz = 0; ill = 0; ov = 0; lat = 1;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin r = a + b; s = sa + sb; ov = (s != longint'($signed(r))); end
            4'd3: r = a ^ b;
            4'd4: r = ~(a | b);
            4'd5: r = (a < b) ? 32'd1 : 32'd0;
            4'd6: begin r = a - b; s = sa - sb; ov = (s != longint'($signed(r))); end
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: begin p = 64'(a) * 64'(b); r = p[31:0]; rh = p[63:32]; lat = W + 1; end
            4'd9: begin
                if (b == 0) begin r = 32'hFFFFFFFF; rh = a; dz = 1; end
                else begin r = a / b; rh = a % b; lat = W + 1; end
            end
            default: ill = 1;
        endcase
`ifndef MULTICYCLE_ALU_OVERFLOW_EN
        ov = 0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge where the result is visible
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er, erh;
        logic        edz, eill, eov;
        int          elat, lat;
        bit          got, busy_rdy;
        model_op(op, a, b, er, erh, edz, eill, eov, elat);
        control_signal = op; operand_a = a; operand_b = b; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        got = 0;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin got = 1; break; end
            @(negedge clock); #1;
        end
        if (!got) begin
            check_val({tag, " accept"}, 64'(0), 64'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        operand_a = $urandom; operand_b = $urandom; control_signal = 4'($urandom);
        lat = 1; got = 0; busy_rdy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (out_valid) begin got = 1; break; end
            if (in_ready) busy_rdy = 1;
            @(posedge clock);
            lat++;
        end
        if (!got) begin
            check_val({tag, " out_valid timeout"}, 64'(0), 64'(1));
            return;
        end
        check_val({tag, " latency"}, 64'(lat), 64'(elat));
        check_val({tag, " result"}, 64'(result), 64'(er));
        check_val({tag, " result_hi"}, 64'(result_hi), 64'(erh));
        check_val({tag, " is_zero"}, 64'(is_zero), 64'(er == 0));
        check_val({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
        check_val({tag, " illegal_op"}, 64'(illegal_op), 64'(eill));
        check_val({tag, " overflow"}, 64'(overflow), 64'(eov));
        if (elat > 1) check_val({tag, " in_ready while busy"}, 64'(busy_rdy), 64'(0));
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        operand_a = '0; operand_b = '0; control_signal = '0;
        repeat (3) @(negedge clock);
        check_val("reset out_valid", 64'(out_valid), 64'(0));
        check_val("reset result", 64'(result), 64'(0));
        check_val("reset result_hi", 64'(result_hi), 64'(0));
        check_val("reset flags", 64'({is_zero, div_by_zero, illegal_op, overflow}), 64'(0));
        check_val("reset in_ready", 64'(in_ready), 64'(1));
        reset_n = 1'b1;
        @(negedge clock);

        run_op("add ovf", 4'b0010, 32'h7FFFFFFF, 32'h1);

        // SUB then SLT back to back with out_ready held high
        control_signal = 4'b0110; operand_a = 32'd5; operand_b = 32'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        control_signal = 4'b0111; operand_a = 32'hFFFFFFFF; operand_b = 32'd1;
        @(negedge clock);
        check_val("b2b sub valid", 64'(out_valid), 64'(1));
        check_val("b2b sub result", 64'(result), 64'(0));
        check_val("b2b sub is_zero", 64'(is_zero), 64'(1));
        check_val("b2b sub in_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check_val("b2b slt valid", 64'(out_valid), 64'(1));
        check_val("b2b slt result", 64'(result), 64'(1));
        check_val("b2b slt is_zero", 64'(is_zero), 64'(0));
        run_op("sltu", 4'b0101, 32'hFFFFFFFF, 32'h1);

        run_op("mul max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("divu 100/7", 4'b1001, 32'd100, 32'd7);
        run_op("divu 9/0", 4'b1001, 32'd9, 32'd0);

        // Stall in DONE while a new op waits
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        control_signal = 4'b0010; operand_a = 32'd3; operand_b = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock); #1;
        control_signal = 4'b0011; operand_a = 32'h0000F0F0; operand_b = 32'h00000FF0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_val("stall out_valid", 64'(out_valid), 64'(1));
            check_val("stall result", 64'(result), 64'(7));
            check_val("stall in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1; #1;
        check_val("stall release in_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        check_val("stall new valid", 64'(out_valid), 64'(1));
        check_val("stall new result", 64'(result), 64'(32'h0000FF00));

        // Reset in the middle of a division
        control_signal = 4'b1001; operand_a = 32'hDEADBEEF; operand_b = 32'h00001234; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check_val("div accept in_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("midreset out_valid", 64'(out_valid), 64'(0));
        check_val("midreset result", 64'(result), 64'(0));
        check_val("midreset result_hi", 64'(result_hi), 64'(0));
        check_val("midreset flags", 64'({is_zero, div_by_zero, illegal_op, overflow}), 64'(0));
        check_val("midreset in_ready", 64'(in_ready), 64'(1));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("postreset in_ready", 64'(in_ready), 64'(1));
        check_val("postreset out_valid", 64'(out_valid), 64'(0));
        run_op("illegal 1111", 4'b1111, 32'h12345678, 32'h9ABCDEF0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), rand_val(), rand_val());
        end

        in_valid = 1'b0;
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
